// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Bursts of up to MAX_BURST words; a local credit counter keeps the FIFO from overflowing.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    input  logic                          fifo_rd_pop_i,
    output logic [ADDRESS_WIDTH:0]        level_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          underflow_err_o
);

    localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
    localparam int unsigned GidW  = $clog2(NUM_REQ);
    localparam int unsigned LvlW  = ADDRESS_WIDTH + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [GidW-1:0]       grant_q, grant_d;
    logic [GidW-1:0]       last_q, last_d;
    logic [LvlW-1:0]       burst_q, burst_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  uflow_q, uflow_d;
    logic                  has_credit;
    logic                  accept;
    logic [DATA_WIDTH-1:0] grant_word;

    // First valid requester searching upward from last+1, wrapping modulo NUM_REQ.
    function automatic logic [GidW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [GidW-1:0]    last);
        int idx;
        rr_pick = last;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(last) + k) % int'(NUM_REQ);
            if (v[idx]) rr_pick = GidW'(idx);
        end
    endfunction

    assign has_credit = (level_q < LvlW'(Depth));
    assign grant_word = req_data_i[int'(grant_q)*int'(DATA_WIDTH) +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_d     = burst_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    grant_d = rr_pick(req_valid_i, last_q);
                    last_d  = grant_d;
                    burst_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                req_ready_o[grant_q] = has_credit;
                accept = req_valid_i[grant_q] & has_credit;
                if (accept) begin
                    wr_en_d = 1'b1;
                    data_d  = grant_word;
                    burst_d = burst_q + LvlW'(1);
                    if (burst_q == LvlW'(MAX_BURST - 1)) state_d = StIdle;
                end else if (!req_valid_i[grant_q]) begin
                    // Requester withdrew; a credit stall with valid held keeps the grant.
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d = level_q;
        uflow_d = uflow_q;
        if (fifo_rd_pop_i && level_q == '0) uflow_d = 1'b1;
        if (accept && !fifo_rd_pop_i) begin
            level_d = level_q + LvlW'(1);
        end else if (!accept && fifo_rd_pop_i && level_q != '0) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= GidW'(NUM_REQ - 1);
            burst_q <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            level_q <= '0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            level_q <= level_d;
            uflow_q <= uflow_d;
        end
    end

    assign fifo_wr_en_o    = wr_en_q;
    assign fifo_data_in_o  = data_q;
    assign level_o         = level_q;
    assign grant_id_o      = grant_q;
    assign busy_o          = (state_q == StGrant);
    assign underflow_err_o = uflow_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of grants, bursts, credits and write latency.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     valid;
    logic [N*W-1:0]   data;
    logic             pop;
    logic [N-1:0]     ready;
    logic             wr_en;
    logic [W-1:0]     wdata;
    logic [AW:0]      level;
    logic [1:0]       gid;
    logic             busy;
    logic             uf;

    int n_tot = 0;
    int n_bad = 0;

    // Model state
    bit         m_busy;
    int         m_gid, m_last, m_cnt, m_level;
    bit         m_uf, m_wr;
    logic [W-1:0] m_wdata;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(W), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready), .fifo_wr_en_o(wr_en), .fifo_data_in_o(wdata),
        .fifo_rd_pop_i(pop), .level_o(level), .grant_id_o(gid), .busy_o(busy),
        .underflow_err_o(uf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
        m_level = 0; m_uf = 0; m_wr = 0; m_wdata = '0;
    endtask

    function automatic logic [N*W-1:0] pack(input int idx, input logic [W-1:0] w);
        pack = '0;
        pack[idx*W +: W] = w;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        for (int i = 0; i < N; i++) rand_data[i*W +: W] = W'($urandom);
    endfunction

    function automatic logic [N-1:0] rand_valid();
        for (int i = 0; i < N; i++) rand_valid[i] = ($urandom_range(0, 99) < 70);
    endfunction

    // One clock: drive at negedge, compare outputs, then advance the model across the posedge.
    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic p);
        logic [N-1:0] exp_ready;
        bit acc;
        bit done;
        @(negedge clk);
        valid = v; data = d; pop = p;
        #1;
        exp_ready = '0;
        if (m_busy && m_level < DEPTH) exp_ready[m_gid] = 1'b1;
        check_eq("ready", 32'(ready), 32'(exp_ready));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("grant_id", 32'(gid), 32'(m_gid));
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("underflow", 32'(uf), 32'(m_uf));
        check_eq("wr_en", 32'(wr_en), 32'(m_wr));
        if (m_wr) check_eq("wr_data", 32'(wdata), 32'(m_wdata));

        acc  = m_busy && v[m_gid] && (m_level < DEPTH);
        m_wr = acc;
        if (acc) m_wdata = d[m_gid*W +: W];
        if (p && m_level == 0) m_uf = 1;
        if (acc && !p) m_level++;
        else if (p && !acc && m_level > 0) m_level--;
        if (!m_busy) begin
            if (v != '0) begin
                done = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!done && v[(m_last + k) % N]) begin
                        m_gid = (m_last + k) % N;
                        done  = 1;
                    end
                end
                m_last = m_gid; m_cnt = 0; m_busy = 1;
            end
        end else if (acc) begin
            m_cnt++;
            if (m_cnt == MB) m_busy = 0;
        end else if (!v[m_gid]) begin
            m_busy = 0;
        end
    endtask

    // Assert reset between clock edges with traffic still applied; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_ready"}, 32'(ready), 32'd0);
        check_eq({tag, "_level"}, 32'(level), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_uf"}, 32'(uf), 32'd0);
        check_eq({tag, "_gid"}, 32'(gid), 32'd0);
        model_reset();
        valid = '0; data = '0; pop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; valid = '0; data = '0; pop = 1'b0;
        model_reset();
        valid = 4'hF; pop = 1'b1;
        do_reset("rst_init");

        // Requester 2 sends A1, A2, A3 then withdraws
        cyc(4'b0100, pack(2, 8'hA1), 1'b0);
        cyc(4'b0100, pack(2, 8'hA1), 1'b0);
        cyc(4'b0100, pack(2, 8'hA2), 1'b0);
        cyc(4'b0100, pack(2, 8'hA3), 1'b0);
        cyc(4'b0000, '0, 1'b0);
        cyc(4'b0000, '0, 1'b0);
        check_eq("t2_level", 32'(level), 32'd3);
        check_eq("t2_busy", 32'(busy), 32'd0);
        check_eq("t2_gid_hold", 32'(gid), 32'd2);

        // All requesters saturate the FIFO, then one pop frees a single credit
        do_reset("rst_t3");
        for (int i = 0; i < 22; i++) cyc(4'hF, rand_data(), 1'b0);
        check_eq("t3_level", 32'(level), 32'd16);
        check_eq("t3_gid", 32'(gid), 32'd0);
        check_eq("t3_stall_ready", 32'(ready), 32'd0);
        check_eq("t3_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) cyc(4'hF, rand_data(), 1'b0);
        cyc(4'hF, rand_data(), 1'b1);
        cyc(4'hF, rand_data(), 1'b0);
        cyc(4'hF, rand_data(), 1'b0);
        check_eq("t4_level", 32'(level), 32'd16);
        check_eq("t4_ready", 32'(ready), 32'd0);

        // Accept and pop in the same cycle at level 8
        do_reset("rst_t5");
        for (int i = 0; i < 11; i++) cyc(4'b0001, rand_data(), 1'b0);
        cyc(4'b0001, rand_data(), 1'b1);
        cyc(4'b0001, rand_data(), 1'b0);
        check_eq("t5_level", 32'(level), 32'd8);
        check_eq("t5_wr_en", 32'(wr_en), 32'd1);

        // Underflow is sticky through traffic
        do_reset("rst_t6");
        cyc(4'b0000, '0, 1'b1);
        cyc(4'b0000, '0, 1'b0);
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_uf", 32'(uf), 32'd1);
        for (int i = 0; i < 200; i++)
            cyc(rand_valid(), rand_data(), 1'($urandom_range(0, 99) < 30));
        check_eq("t6_uf_sticky", 32'(uf), 32'd1);

        // Random traffic with alternating pop pressure and mid-traffic resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 300; i++)
                cyc(rand_valid(), rand_data(),
                    1'($urandom_range(0, 99) < ((r % 2) != 0 ? 50 : 15)));
            do_reset("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the synchronous FIFO among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. The arbiter grants bursts of up to MAX_BURST words.
- It tracks FIFO occupancy with its own credit counter, so it never writes into a full FIFO. It does not rely on the FIFO's late-registered full flag.
- Sits directly in front of the fifo write port; the consumer side reports each removed word via fifo_rd_pop.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, word width; matches the FIFO
- ADDRESS_WIDTH, 4, FIFO address width; DEPTH = 2**ADDRESS_WIDTH
- MAX_BURST, 4, max consecutive words per grant (1..DEPTH)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester word valid
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; combinational from state/credits
- fifo_wr_en  output  1  registered write strobe to FIFO
- fifo_data_in  output  DATA_WIDTH  registered write data to FIFO
- fifo_rd_pop  input  1  one-cycle pulse: FIFO delivered one word
- level  output  ADDRESS_WIDTH+1  credit count, 0..DEPTH
- grant_id  output  $clog2(NUM_REQ)  current/last granted requester
- busy  output  1  high in GRANT state
- underflow_err  output  1  sticky: pop seen with level==0

Behaviour:
- Reset (reset=0, asynchronous) drives the following immediately:
  - state=IDLE, req_ready=0, fifo_wr_en=0, fifo_data_in=0
  - level=0, grant_id=0, busy=0, underflow_err=0
  - internal last_grant=NUM_REQ-1, so requester 0 has first priority
  - burst_cnt=0
- FSM states: IDLE, GRANT.
- IDLE:
  - req_ready=0.
  - If any req_valid, pick the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register it into grant_id and last_grant, clear burst_cnt, go to GRANT.
  - Arbitration costs exactly one cycle.
- GRANT:
  - req_ready[grant_id] = (level < DEPTH); all other ready bits are 0.
  - Accept = req_valid[grant_id] & req_ready[grant_id].
  - On accept: next cycle fifo_wr_en=1 and fifo_data_in=accepted word (latency 1); burst_cnt increments.
  - fifo_wr_en=0 in every cycle not following an accept.
- GRANT -> IDLE when either of these holds:
  - accept with burst_cnt==MAX_BURST-1 (burst complete), or
  - req_valid[grant_id]==0 (requester withdrew).
- Credit stall: valid high but level==DEPTH → stay in GRANT with ready=0. Burst not terminated, no timeout.
- level update per cycle: +1 on accept, -1 on fifo_rd_pop, unchanged if both or neither.
  - Ready uses current level only; a pop in the same cycle does not enable ready at level==DEPTH.
- fifo_rd_pop with level==0: level stays 0, underflow_err set, held until reset.
- Requester deasserting valid without handshake is legal; no word is written.
- Width rules:
  - level saturates at 0 and DEPTH by construction; never wraps.
  - grant_id uses modulo-NUM_REQ increment for non-power-of-2 NUM_REQ.
- Reset asserted mid-burst: all outputs clear asynchronously. Any accepted-but-unwritten word is dropped.
- grant_id holds its value in IDLE.

Test Plan:
1. Reset asserted at arbitrary time with traffic -> same cycle fifo_wr_en=0, req_ready=0, level=0, busy=0, underflow_err=0.
2. Requester 2 presents 0xA1,0xA2,0xA3 back-to-back:
   - cycle after valid: grant_id=2, busy=1
   - three accepts, then fifo_wr_en high 3 cycles (each one cycle after its accept) carrying 0xA1,0xA2,0xA3
   - level=3, FSM returns to IDLE when valid drops
3. All four requesters valid continuously, no pops:
   - grant order 0,1,2,3; bursts of exactly 4 words; one idle arbitration cycle between bursts
   - after 16 words, level=16 and requester 0's second grant stalls with ready=0
4. At level=16 (stalled), one fifo_rd_pop:
   - level=15 next cycle, ready asserts, one accept, level=16 again
   - no fifo_wr_en ever issued while level==16
5. Level=8, accept and fifo_rd_pop in same cycle -> level stays 8, fifo_wr_en=1 next cycle.
6. Level=0, fifo_rd_pop pulse -> level=0, underflow_err=1, which stays high through later traffic until reset.
